// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point add/subtract unit.
// Holds the FSM state enumeration, default field widths, guard-bit count and
// constructors for the canonical NaN and signed infinity encodings.
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int GRS_W     = 3;   // guard, round, sticky
  localparam int FP_MAX_W  = 128; // widest format the constructors can build

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  // Signed infinity: all-ones exponent, zero mantissa. Callers truncate to W.
  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] one;
    logic [FP_MAX_W-1:0] v;
    one = FP_MAX_W'(1);
    v   = ((one << exp_w) - one) << man_w;
    v   = v | (FP_MAX_W'(sign) << (exp_w + man_w));
    return v;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational logarithmic right shifter with sticky output.
// Ports:
//   i_data   [WIDTH-1:0]  value to shift right
//   i_shamt  [SHW-1:0]    shift distance (may exceed WIDTH)
//   o_data   [WIDTH-1:0]  shifted value
//   o_sticky              OR of every bit shifted out of the bottom
module fp_align_shift #(
  parameter int WIDTH = 27,
  parameter int SHW   = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sticky
);

  logic [WIDTH-1:0] w_stage [SHW+1];
  logic             w_lost  [SHW+1];

  assign w_stage[0] = i_data;
  assign w_lost[0]  = 1'b0;

  genvar gi;
  for (gi = 0; gi < SHW; gi++) begin : g_stage
    localparam int AMT = 1 << gi;
    if (AMT >= WIDTH) begin : g_all
      // This stage alone pushes everything out; all of it becomes sticky.
      assign w_stage[gi+1] = i_shamt[gi] ? '0 : w_stage[gi];
      assign w_lost[gi+1]  = w_lost[gi] | (i_shamt[gi] & (|w_stage[gi]));
    end else begin : g_part
      assign w_stage[gi+1] = i_shamt[gi] ? (w_stage[gi] >> AMT) : w_stage[gi];
      assign w_lost[gi+1]  = w_lost[gi] | (i_shamt[gi] & (|w_stage[gi][AMT-1:0]));
    end
  end

  assign o_data   = w_stage[SHW];
  assign o_sticky = w_lost[SHW];

endmodule

// File: rtl/float_addsub_seq.sv
// Multi-cycle IEEE-style floating-point adder/subtractor, one op in flight.
// Denormals are flushed to zero; rounding is round-to-nearest-even.
// Ports:
//   clk, rst (sync, active high)
//   in_valid/in_ready, a, b, sub   : operation handshake, sub=1 means a-b
//   out_valid/out_ready, result    : result handshake
//   ovf : result overflowed to infinity, inv : invalid op, result is NaN
module float_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = 1 + MAN_W + GRS_W;  // hidden bit, field, G/R/S
  localparam logic [EXP_W:0] EXP_ONE  = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_a, r_b;          // r_b carries the effective sign
  logic           r_sign_l, r_sign_s;
  logic [EXP_W:0] r_exp;
  logic [MW-1:0]  r_man_l, r_man_s;
  logic [MW:0]    r_sum;             // extra top bit catches the add carry
  logic [W-1:0]   r_result;
  logic           r_ovf, r_inv, r_spec_hold;

  // ---------------- unpack / classify ----------------
  logic [EXP_W-1:0] w_ea, w_eb, w_el, w_es, w_diff;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_swap;
  logic [W-1:0]     w_l, w_s;
  logic [MW-1:0]    w_s_ext, w_s_sh;
  logic             w_s_stk;

  assign w_ea     = r_a[W-2:MAN_W];
  assign w_eb     = r_b[W-2:MAN_W];
  assign w_a_nan  = (&w_ea) & (|r_a[MAN_W-1:0]);
  assign w_b_nan  = (&w_eb) & (|r_b[MAN_W-1:0]);
  assign w_a_inf  = (&w_ea) & ~(|r_a[MAN_W-1:0]);
  assign w_b_inf  = (&w_eb) & ~(|r_b[MAN_W-1:0]);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  // Magnitude order falls out of comparing {exponent, mantissa} as an integer.
  assign w_swap  = r_b[W-2:0] > r_a[W-2:0];
  assign w_l     = w_swap ? r_b : r_a;
  assign w_s     = w_swap ? r_a : r_b;
  assign w_el    = w_l[W-2:MAN_W];
  assign w_es    = w_s[W-2:MAN_W];
  assign w_diff  = w_el - w_es;
  assign w_s_ext = {1'b1, w_s[MAN_W-1:0], {GRS_W{1'b0}}};

  fp_align_shift #(.WIDTH(MW), .SHW(EXP_W)) u_align (
    .i_data   (w_s_ext),
    .i_shamt  (w_diff),
    .o_data   (w_s_sh),
    .o_sticky (w_s_stk)
  );

  logic         w_special, w_spec_inv;
  logic [W-1:0] w_spec_res;

  always_comb begin
    w_special  = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[W-1] != r_b[W-1]))) begin
      w_spec_res = W'(fp_nan(EXP_W, MAN_W));
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = W'(fp_inf(r_a[W-1], EXP_W, MAN_W));
    end else if (w_b_inf) begin
      w_spec_res = W'(fp_inf(r_b[W-1], EXP_W, MAN_W));
    end else if (w_a_zero && w_b_zero) begin
      w_spec_res = {r_a[W-1] & r_b[W-1], {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_spec_res = r_b;
    end else if (w_b_zero) begin
      w_spec_res = r_a;
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- shared mantissa adder ----------------
  logic [MW:0]    w_add_x, w_add_y, w_add;
  logic           w_add_sub, w_round_up;
  logic [EXP_W:0] w_round_exp;

  // Round to nearest even: guard set and (anything below it or odd LSB).
  assign w_round_up = r_sum[GRS_W-1] & (r_sum[GRS_W-2] | r_sum[0] | r_sum[GRS_W]);

  always_comb begin
    w_add_x   = {1'b0, r_man_l};
    w_add_y   = {1'b0, r_man_s};
    w_add_sub = r_sign_l ^ r_sign_s;
    if (r_state == ST_ROUND) begin
      w_add_x   = r_sum;
      w_add_y   = (MW+1)'(w_round_up) << GRS_W;
      w_add_sub = 1'b0;
    end
    w_add = w_add_sub ? (w_add_x - w_add_y) : (w_add_x + w_add_y);
  end

  // A rounding carry leaves an all-zero field, so only the exponent moves.
  assign w_round_exp = r_exp + {{EXP_W{1'b0}}, w_add[MW]};

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ST_ALIGN;
      end
      // Specials spend two cycles here: classify, then present the result.
      ST_ALIGN: w_state_next = w_special ? (r_spec_hold ? ST_DONE : ST_ALIGN) : ST_ADD;
      ST_ADD:   w_state_next = (w_add_sub && (w_add == '0)) ? ST_DONE : ST_NORM;
      ST_NORM: begin
        if (r_sum[MW] || r_sum[MW-1]) w_state_next = ST_ROUND;
        else if (r_exp == EXP_ONE)    w_state_next = ST_DONE;  // flush
      end
      ST_ROUND: w_state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_sign_l <= 1'b0; r_sign_s <= 1'b0;
      r_exp <= '0; r_man_l <= '0; r_man_s <= '0; r_sum <= '0;
      r_result <= '0; r_ovf <= 1'b0; r_inv <= 1'b0; r_spec_hold <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a         <= a;
            r_b         <= {b[W-1] ^ sub, b[W-2:0]};
            r_spec_hold <= 1'b0;
          end
        end
        ST_ALIGN: begin
          r_spec_hold <= w_special;
          r_sign_l    <= w_l[W-1];
          r_sign_s    <= w_s[W-1];
          r_exp       <= {1'b0, w_el};
          r_man_l     <= {1'b1, w_l[MAN_W-1:0], {GRS_W{1'b0}}};
          r_man_s     <= {w_s_sh[MW-1:1], w_s_sh[0] | w_s_stk};
          if (w_special) begin
            r_result <= w_spec_res;
            r_ovf    <= 1'b0;
            r_inv    <= w_spec_inv;
          end
        end
        ST_ADD: begin
          r_sum <= w_add;
          if (w_add_sub && (w_add == '0)) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
          end
        end
        ST_NORM: begin
          if (r_sum[MW]) begin
            // Carry out: one right shift, the dropped bit folds into sticky.
            r_sum <= {1'b0, r_sum[MW:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EXP_ONE;
          end else if (!r_sum[MW-1]) begin
            if (r_exp == EXP_ONE) begin
              r_result <= {r_sign_l, {(W-1){1'b0}}};
              r_ovf    <= 1'b0;
              r_inv    <= 1'b0;
            end else begin
              r_sum <= {r_sum[MW-1:0], 1'b0};
              r_exp <= r_exp - EXP_ONE;
            end
          end
        end
        ST_ROUND: begin
          r_inv <= 1'b0;
          if (w_round_exp >= EXP_ONES) begin
            r_result <= W'(fp_inf(r_sign_l, EXP_W, MAN_W));
            r_ovf    <= 1'b1;
          end else begin
            r_result <= {r_sign_l, w_round_exp[EXP_W-1:0], w_add[MW-2:GRS_W]};
            r_ovf    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_ovf <= 1'b0;
            r_inv <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;
  assign inv    = r_inv;

endmodule

// File: tb/tb_float_addsub_seq.sv
module tb_float_addsub_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, ovf, inv;
  logic [31:0] a, b, result;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  float_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .inv(inv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact sum as a wide integer (unit = smallest normal ulp),
  // then flush/round/overflow applied to that exact value.
  function automatic void fp_model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                   output logic [31:0] res, output logic o_ovf, output logic o_inv);
    logic sx, sy, sr;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    logic [319:0] mx, my, mag, one, rem, half, q;
    int p, e, sh;
    sx = x[31]; sy = y[31] ^ s;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0]; fy = y[22:0];
    res = 32'd0; o_ovf = 1'b0; o_inv = 1'b0;
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0) || (ex == 8'hFF && ey == 8'hFF && sx != sy)) begin
      res = 32'h7FC00000; o_inv = 1'b1;
    end else if (ex == 8'hFF) res = {sx, 8'hFF, 23'd0};
    else if (ey == 8'hFF) res = {sy, 8'hFF, 23'd0};
    else if (ex == 0 && ey == 0) res = {sx & sy, 31'd0};
    else if (ex == 0) res = {sy, y[30:0]};
    else if (ey == 0) res = x;
    else begin
      one = 320'd1;
      mx = {296'd0, 1'b1, fx} << (ex - 8'd1);
      my = {296'd0, 1'b1, fy} << (ey - 8'd1);
      if (sx == sy) begin mag = mx + my; sr = sx; end
      else if (mx >= my) begin mag = mx - my; sr = sx; end
      else begin mag = my - mx; sr = sy; end
      if (mag == 0) res = 32'd0;
      else begin
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) res = {sr, 31'd0};
        else begin
          sh = p - 23;
          q = mag >> sh;
          if (sh > 0) begin
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + one;
          end
          if (q[24]) begin q = q >> 1; e = e + 1; end
          if (e >= 255) begin res = {sr, 8'hFF, 23'd0}; o_ovf = 1'b1; end
          else res = {sr, 8'(e), q[22:0]};
        end
      end
    end
  endfunction

  // One full transaction; exp_lat < 0 skips the latency check.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input int hold, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_ovf, input logic exp_inv);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_inv"}, 32'(inv), 32'(exp_inv));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_result"}, result, exp_res);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    $display("op %s a=%h b=%h sub=%0d -> result=%h ovf=%0d inv=%0d lat=%0d",
             tag, ta, tb_v, ts, result, ovf, inv, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic eo, ei, rs, seen;
    int e, kind;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_inv", 32'(inv), 32'd0);

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 0, 4, 32'h40000000, 1'b0, 1'b0);
    run_op("sub_k1",       32'h3FC00000, 32'h3F800000, 1'b1, 0, 5, 32'h3F000000, 1'b0, 1'b0);
    run_op("cancel",       32'h3F800000, 32'h3F800000, 1'b1, 0, -1, 32'h00000000, 1'b0, 1'b0);
    run_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 0, 4, 32'h3F800000, 1'b0, 1'b0);
    run_op("tie_odd_up",   32'h3F800001, 32'h33800000, 1'b0, 0, 4, 32'h3F800002, 1'b0, 1'b0);
    run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 4, 32'h7F800000, 1'b1, 1'b0);
    run_op("inf_minus_inf",32'h7F800000, 32'hFF800000, 1'b0, 0, 2, 32'h7FC00000, 1'b0, 1'b1);
    run_op("zero_minus_x", 32'h00000000, 32'h3F800000, 1'b1, 0, 2, 32'hBF800000, 1'b0, 1'b0);
    run_op("negzero_sum",  32'h80000000, 32'h80000000, 1'b0, 0, 2, 32'h80000000, 1'b0, 1'b0);
    run_op("deep_cancel",  32'h3F800001, 32'h3F800000, 1'b1, 0, 27, 32'h34000000, 1'b0, 1'b0);
    run_op("flush_neg",    32'h80800001, 32'h80800000, 1'b1, 0, -1, 32'h80000000, 1'b0, 1'b0);
    run_op("hold10",       32'h40000000, 32'hC0800000, 1'b0, 10, 5, 32'hC0000000, 1'b0, 1'b0);

    // Reset while a long normalisation is in progress.
    a = 32'h3F800001; b = 32'h3F800000; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("norm_busy_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_norm_out_valid", 32'(out_valid), 32'd0);
    check("rst_norm_in_ready", 32'(in_ready), 32'd1);
    check("rst_norm_result", result, 32'd0);
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1 seen |= out_valid; end
    check("rst_norm_no_output", 32'(seen), 32'd0);
    $display("op rst_in_norm a=3f800001 b=3f800000 sub=1 -> discarded");

    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 15));
      if (kind < 10) begin
        e = int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        rb[30:23] = 8'(e);
      end else if (kind == 10) begin
        rb[30:0] = ra[30:0] ^ 31'($urandom_range(0, 7));
      end else if (kind == 11) begin
        ra[30:23] = 8'hFE; rb[30:23] = 8'(253 + $urandom_range(0, 1));
      end else if (kind == 12) begin
        rb[30:23] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
      end else if (kind == 13) begin
        rb[30:23] = 8'h01; ra[30:23] = 8'(1 + $urandom_range(0, 1));
      end
      fp_model(ra, rb, rs, er, eo, ei);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, int'($urandom_range(0, 3)), -1, er, eo, ei);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/float_addsub_seq.md
FLOAT_ADDSUB_SEQ -- requirements
Module: float_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width (total width W = 1+EXP_W+MAN_W).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair and op valid.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a, b  input  W each  IEEE-style operands: sign, exponent, mantissa.
REQ-008 sub  input  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  rounded sum or difference.
REQ-012 ovf  output  1  result overflowed to infinity.
REQ-013 inv  output  1  invalid operation, result is canonical NaN.

Function
REQ-014 Transfers: input when in_valid&&in_ready; output when out_valid&&out_ready; one operation in flight at a time.
REQ-015 FSM states IDLE, ALIGN, ADD, NORM, ROUND, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->ALIGN on input transfer: latch a, b; effective sign of b = b[W-1]^sub; unpack with hidden 1, extend by guard/round/sticky bits.
REQ-017 Exponent field 0 treated as +/-0 (denormals flushed, no underflow flag); all-ones field is Inf/NaN.
REQ-018 Special cases resolved in ALIGN, jump to DONE: NaN in or Inf-Inf -> {0,all-ones,1 then zeros}, inv=1; single Inf (or same-sign Infs) -> that Inf; one zero operand -> other operand; both zero -> +0 unless both effective signs negative.
REQ-019 ALIGN (1 cycle): swap so larger magnitude is first; right-shift smaller mantissa by exponent difference, OR-ing shifted-out bits into sticky; differences >= MAN_W+3 reduce it to sticky only.
REQ-020 ADD (1 cycle): add mantissas when signs equal, else subtract smaller from larger; result sign = sign of larger magnitude; exact zero difference -> +0 and go to DONE.
REQ-021 NORM: carry-out -> one right shift (sticky kept), exponent+1, 1 cycle; else left shift one bit per cycle, exponent-1 each, until leading 1 in hidden position; exponent reaching 0 -> flush to signed zero.
REQ-022 ROUND (1 cycle): round-to-nearest-even on guard/round/sticky; mantissa carry renormalises, exponent+1; exponent reaching all-ones -> signed Inf, ovf=1.
REQ-023 Latency: out_valid asserted 4+k cycles after input transfer edge, k = left-shift count (k=0 when no shift or carry shift); special cases 2 cycles.
REQ-024 DONE holds result, ovf, inv stable until output transfer, then -> IDLE; new input accepted no earlier than the next cycle.
REQ-025 ovf and inv are zero except on the results they qualify.

Reset
REQ-026 rst takes priority over any transfer, any state: state=IDLE, in_ready=1 after reset, out_valid=0, result=0, ovf=0, inv=0.
REQ-027 Operation in flight during rst is discarded, no output produced.

Structure
REQ-028 Shared package fp_pkg holds state enumeration, default EXP_W/MAN_W, guard-bit count (3) and canonical NaN/Inf constructors.
REQ-029 One sub-module fp_align_shift: combinational right barrel shift with sticky output, parametrised by width.
REQ-030 Mantissa add/subtract uses a single adder shared across ADD and ROUND.

Verification (defaults, hex)
REQ-031 3F800000 + 3F800000, sub=0 -> 40000000, out_valid 4 cycles after accept, ovf=inv=0.
REQ-032 3FC00000 - 3F800000 (sub=1) -> 3F000000 after 5 cycles (k=1); 3F800000 - 3F800000 -> 00000000.
REQ-033 3F800000 + 33800000 -> 3F800000 (tie to even); 3F800001 + 33800000 -> 3F800002.
REQ-034 7F7FFFFF + 7F7FFFFF -> 7F800000, ovf=1; 7F800000 + FF800000 -> 7FC00000, inv=1.
REQ-035 out_ready held low 10 cycles in DONE -> result stable, in_ready=0; rst in NORM -> out_valid=0, in_ready=1 next cycle.
